// File: rtl/pim_cmp_pkg.sv
// Shared definitions for the digit-serial comparator: op encodings, FSM states
// and the final result decode.
`timescale 1ns/1ps
package pim_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_LT = 2'b00,
    CMP_LE = 2'b01,
    CMP_EQ = 2'b10,
    CMP_NE = 2'b11
  } cmp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } cmp_state_e;

  function automatic logic cmp_result(input cmp_op_e op, input logic lt, input logic eq);
    logic res;
    res = 1'b0;
    case (op)
      CMP_LT: res = lt;
      CMP_LE: res = lt | eq;
      CMP_EQ: res = eq;
      CMP_NE: res = ~eq;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmp_serial_nbit_if.sv
// Request/response bundle of the digit-serial comparator.
`timescale 1ns/1ps
interface cmp_serial_nbit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             y;

  modport master (
    output in_valid, a, b, op, is_signed, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, op, is_signed, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/cmp_serial_digit.sv
// One digit of the serial compare: borrow-out of a_d - b_d - bin and digit equality.
`timescale 1ns/1ps
module cmp_serial_digit #(
  parameter int DIGIT     = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin,
  output logic             bout,
  output logic             deq
);

  assign deq = (a_d == b_d);

  generate
    if (IMPL_TYPE == 1) begin : g_ripple
      // Explicit per-bit borrow chain instead of a wide subtractor.
      logic [DIGIT:0] brw;
      assign brw[0] = bin;
      for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign brw[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & brw[i]);
      end
      assign bout = brw[DIGIT];
    end else begin : g_arith
      assign bout = ({1'b0, a_d} < ({1'b0, b_d} + (DIGIT+1)'(bin)));
    end
  endgenerate

endmodule

// File: rtl/cmp_serial_nbit.sv
// Digit-serial N-bit comparator: one DIGIT-bit slice per cycle, LSB digit first,
// with a valid/ready request and result handshake.
`timescale 1ns/1ps
module cmp_serial_nbit
  import pim_cmp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DIGIT     = 4,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = $clog2(NDIG) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  cmp_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             eq_q, eq_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  cmp_op_e          op_q, op_d;
  logic             y_q, y_d;

  logic dig_bout;
  logic dig_eq;

  // Operands are shift registers: the current digit is always in the low bits.
  cmp_serial_digit #(
    .DIGIT    (DIGIT),
    .IMPL_TYPE(IMPL_TYPE)
  ) u_digit (
    .a_d (opa_q[DIGIT-1:0]),
    .b_d (opb_q[DIGIT-1:0]),
    .bin (borrow_q),
    .bout(dig_bout),
    .deq (dig_eq)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    eq_d     = eq_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    op_d     = op_q;
    y_d      = y_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Flipping the sign bits turns a signed compare into an unsigned one.
          opa_d    = a ^ (is_signed ? MSB_MASK : '0);
          opb_d    = b ^ (is_signed ? MSB_MASK : '0);
          op_d     = cmp_op_e'(op);
          cnt_d    = '0;
          borrow_d = 1'b0;
          eq_d     = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        borrow_d = dig_bout;
        eq_d     = eq_q & dig_eq;
        opa_d    = opa_q >> DIGIT;
        opb_d    = opb_q >> DIGIT;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          y_d     = cmp_result(op_q, dig_bout, eq_q & dig_eq);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          y_d     = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        y_d     = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      eq_q     <= 1'b1;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= CMP_LT;
      y_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      eq_q     <= eq_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      op_q     <= op_d;
      y_q      <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign y         = y_q;

endmodule

// File: tb/tb_cmp_serial_nbit.sv
// Scoreboard bench for cmp_serial_nbit: an 8-bit/2-bit-digit instance and an
// 8-bit/8-bit-digit instance, checked against an integer-arithmetic model.
`timescale 1ns/1ps
module tb_cmp_serial_nbit;

  typedef struct {
    logic y;
    int   acc;
  } exp_t;

  localparam int NDIG2 = 4;
  localparam int NDIG8 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t q2[$];
  exp_t q8[$];
  bit   pres2 = 1'b0;
  bit   pres8 = 1'b0;
  logic held2 = 1'b0;
  logic held8 = 1'b0;
  int   last_acc = 0;

  cmp_serial_nbit_if #(.WIDTH(8)) if2 ();
  cmp_serial_nbit_if #(.WIDTH(8)) if8 ();

  cmp_serial_nbit #(.WIDTH(8), .DIGIT(2), .IMPL_TYPE(0)) u_dut_w2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (if2.in_valid),
    .in_ready (if2.in_ready),
    .a        (if2.a),
    .b        (if2.b),
    .op       (if2.op),
    .is_signed(if2.is_signed),
    .out_valid(if2.out_valid),
    .out_ready(if2.out_ready),
    .y        (if2.y)
  );

  cmp_serial_nbit #(.WIDTH(8), .DIGIT(8), .IMPL_TYPE(1)) u_dut_w8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (if8.in_valid),
    .in_ready (if8.in_ready),
    .a        (if8.a),
    .b        (if8.b),
    .op       (if8.op),
    .is_signed(if8.is_signed),
    .out_valid(if8.out_valid),
    .out_ready(if8.out_ready),
    .y        (if8.y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: compare the operands as plain integers of the requested signedness.
  function automatic logic refY(input logic [7:0] av, input logic [7:0] bv,
                                input logic [1:0] opv, input logic sg);
    longint x;
    longint z;
    logic   r;
    if (sg) begin
      x = longint'($signed(av));
      z = longint'($signed(bv));
    end else begin
      x = longint'(av);
      z = longint'(bv);
    end
    case (opv)
      2'b00:   r = (x <  z);
      2'b01:   r = (x <= z);
      2'b10:   r = (x == z);
      default: r = (x != z);
    endcase
    return r;
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                               input logic [1:0] opv, input logic sg,
                               input bit rnd_rdy, input bit hold_valid);
    int   waited;
    exp_t e;
    waited = 0;
    while (!(sel ? if8.in_ready : if2.in_ready) && waited < 100) begin
      if (rnd_rdy) begin
        if (sel) if8.out_ready = 1'($urandom_range(0, 1));
        else     if2.out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 100) begin
      checkOutput(sel ? "accept_timeout_w8" : "accept_timeout_w2", 64'd0, 64'd1);
      return;
    end
    e.y      = refY(av, bv, opv, sg);
    e.acc    = cyc + 1;
    last_acc = e.acc;
    if (sel) begin
      if8.a = av; if8.b = bv; if8.op = opv; if8.is_signed = sg; if8.in_valid = 1'b1;
      q8.push_back(e);
    end else begin
      if2.a = av; if2.b = bv; if2.op = opv; if2.is_signed = sg; if2.in_valid = 1'b1;
      q2.push_back(e);
    end
    if (rnd_rdy) begin
      if (sel) if8.out_ready = 1'($urandom_range(0, 1));
      else     if2.out_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    // Scramble the operands so a result that leaks the live inputs is caught.
    if (sel) begin
      if8.in_valid = hold_valid; if8.a = 8'($urandom); if8.b = 8'($urandom);
      if8.op = 2'($urandom); if8.is_signed = 1'($urandom);
    end else begin
      if2.in_valid = hold_valid; if2.a = 8'($urandom); if2.b = 8'($urandom);
      if2.op = 2'($urandom); if2.is_signed = 1'($urandom);
    end
  endtask

  task automatic waitValid2();
    int n;
    n = 0;
    while (!if2.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) checkOutput("valid_timeout_w2", 64'd0, 64'd1);
  endtask

  // Monitor: pops the scoreboard when a new result is presented.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pres2 = 1'b0;
        pres8 = 1'b0;
      end
      if (if2.out_valid) begin
        if (!pres2) begin
          if (q2.size() == 0) begin
            checkOutput("unexpected_result_w2", 64'd1, 64'd0);
          end else begin
            e = q2.pop_front();
            checkOutput("y_w2", 64'(if2.y), 64'(e.y));
            checkOutput("latency_w2", 64'(cyc - e.acc), 64'(NDIG2));
          end
          pres2 = 1'b1;
          held2 = if2.y;
        end else begin
          checkOutput("y_hold_w2", 64'(if2.y), 64'(held2));
        end
        if (if2.out_ready) pres2 = 1'b0;
      end else begin
        checkOutput("y_zero_w2", 64'(if2.y), 64'd0);
      end
      if (if8.out_valid) begin
        if (!pres8) begin
          if (q8.size() == 0) begin
            checkOutput("unexpected_result_w8", 64'd1, 64'd0);
          end else begin
            e = q8.pop_front();
            checkOutput("y_w8", 64'(if8.y), 64'(e.y));
            checkOutput("latency_w8", 64'(cyc - e.acc), 64'(NDIG8));
          end
          pres8 = 1'b1;
          held8 = if8.y;
        end else begin
          checkOutput("y_hold_w8", 64'(if8.y), 64'(held8));
        end
        if (if8.out_ready) pres8 = 1'b0;
      end else begin
        checkOutput("y_zero_w8", 64'(if8.y), 64'd0);
      end
    end
  end

  initial begin : stimulus
    int prev_acc;
    int n;
    logic [7:0] ra;
    logic [7:0] rb;
    if2.in_valid = 1'b0; if2.a = '0; if2.b = '0; if2.op = '0; if2.is_signed = 1'b0; if2.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.op = '0; if8.is_signed = 1'b0; if8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready_w2", 64'(if2.in_ready), 64'd1);
    checkOutput("reset_out_valid_w2", 64'(if2.out_valid), 64'd0);
    checkOutput("reset_y_w2", 64'(if2.y), 64'd0);
    checkOutput("reset_in_ready_w8", 64'(if8.in_ready), 64'd1);
    rst_n = 1'b1;

    // Signed/unsigned boundary operands; first request right after reset release.
    applyStimulus(1'b0, 8'hFF, 8'h01, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'hFF, 8'h01, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h80, 8'h7F, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h80, 8'h7F, 2'b11, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h80, 8'h7F, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h5A, 8'h5A, 2'b10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h5A, 8'h5A, 2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h5A, 8'h5A, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h5A, 8'h5A, 2'b11, 1'b0, 1'b0, 1'b0);

    // Backpressure in DONE while a new request is offered.
    @(posedge clk); #1;
    while (!if2.in_ready) begin @(posedge clk); #1; end
    if2.out_ready = 1'b0;
    applyStimulus(1'b0, 8'h12, 8'h34, 2'b00, 1'b0, 1'b0, 1'b0);
    waitValid2();
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_out_valid", 64'(if2.out_valid), 64'd1);
      checkOutput("stall_in_ready", 64'(if2.in_ready), 64'd0);
      if2.in_valid = 1'b1; if2.a = 8'($urandom); if2.b = 8'($urandom);
      @(posedge clk); #1;
    end
    checkOutput("stall_out_valid_end", 64'(if2.out_valid), 64'd1);
    if2.in_valid  = 1'b0;
    if2.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle_after_handshake_in_ready", 64'(if2.in_ready), 64'd1);
    checkOutput("idle_after_handshake_out_valid", 64'(if2.out_valid), 64'd0);

    // Reset in the middle of BUSY must abort the pending result.
    applyStimulus(1'b0, 8'h03, 8'hF0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(if2.out_valid), 64'd0);
    checkOutput("abort_y", 64'(if2.y), 64'd0);
    checkOutput("abort_in_ready", 64'(if2.in_ready), 64'd1);
    q2.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    applyStimulus(1'b0, 8'hC3, 8'hC3, 2'b01, 1'b1, 1'b0, 1'b0);

    // Single-digit instance: back-to-back requests with in_valid held high.
    prev_acc = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 1'b0, 1'b1);
      if (i > 0) checkOutput("b2b_interval_w8", 64'(last_acc - prev_acc), 64'(NDIG8 + 2));
      prev_acc = last_acc;
    end
    if8.in_valid = 1'b0;

    // Random run on both instances with random consumer backpressure.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      applyStimulus(1'($urandom_range(0, 1)), ra, rb, 2'($urandom), 1'($urandom), 1'b1, 1'b0);
    end

    if2.out_ready = 1'b1;
    if8.out_ready = 1'b1;
    n = 0;
    while ((q2.size() != 0 || q8.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain_w2", 64'(q2.size()), 64'd0);
    checkOutput("drain_w8", 64'(q8.size()), 64'd0);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cmp_serial_nbit.md
CMP_SERIAL_NBIT -- requirements
Module: cmp_serial_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal when WIDTH >= 2 and WIDTH % DIGIT == 0.
REQ-002 SHALL have parameter DIGIT, default 4: bits compared per cycle; legal range 1..WIDTH.
REQ-003 SHALL have parameter IMPL_TYPE, default 0: implementation selector, passed unchanged to the digit slice.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: request valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-008 SHALL have port a, input, WIDTH bits: operand A.
REQ-009 SHALL have port b, input, WIDTH bits: operand B.
REQ-010 SHALL have port op, input, 2 bits: 00 LT (A<B), 01 LE (A<=B), 10 EQ (A==B), 11 NE (A!=B).
REQ-011 SHALL have port is_signed, input, 1 bit: 1 = two's-complement compare, 0 = unsigned compare.
REQ-012 SHALL have port out_valid, output, 1 bit: result valid.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port y, output, 1 bit: compare result.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 out_valid SHALL be 1 only in DONE.
REQ-018 A request SHALL be accepted on a cycle with in_valid=1 and in_ready=1; a, b, op and is_signed are registered at that edge; IDLE->BUSY; digit counter cleared to 0; borrow cleared to 0; eq flag set to 1.
REQ-019 Operand changes after acceptance SHALL have no effect on the result.
REQ-020 In BUSY, each cycle SHALL process one DIGIT-bit digit, LSB digit first, updating:
  - borrow = borrow-out of (A_digit - B_digit - borrow_in);
  - eq = eq AND (A_digit == B_digit).
REQ-021 When is_signed=1, the MSB of both captured operands SHALL be inverted before comparison, so that the signed compare reduces to an unsigned compare.
REQ-022 After NDIG = WIDTH/DIGIT BUSY cycles the counter SHALL wrap to 0 and the FSM SHALL go BUSY->DONE.
REQ-023 Latency SHALL be exactly NDIG cycles from the accept edge to out_valid=1; WIDTH==DIGIT gives 1 cycle.
REQ-024 y SHALL be computed from the final lt (= borrow) and eq values as:
  - LT: lt;
  - LE: lt|eq;
  - EQ: eq;
  - NE: ~eq.
REQ-025 y SHALL be registered and SHALL be stable while out_valid=1.
REQ-026 In DONE with out_ready=0, y and out_valid SHALL hold.
REQ-027 In DONE with out_ready=1, the FSM SHALL go DONE->IDLE on that edge.
REQ-028 A new request SHALL be acceptable on the following cycle, giving a throughput of one result per NDIG+2 cycles.
REQ-029 in_valid SHALL be ignored outside IDLE.
REQ-030 out_ready SHALL be ignored outside DONE.
REQ-031 y SHALL read 0 whenever out_valid=0.

Reset
REQ-032 rst_n=0 SHALL asynchronously force: state IDLE, counter 0, borrow 0, eq 1, y 0, out_valid 0, in_ready 1 (in_ready=1 effective once rst_n is released).
REQ-033 Reset asserted in BUSY or DONE SHALL abort the operation; the pending result SHALL never be presented.
REQ-034 The first request SHALL be accepted on the first rising edge after rst_n deasserts when in_valid=1.

Structure
REQ-035 The op encodings (CMP_LT, CMP_LE, CMP_EQ, CMP_NE) and the FSM state encoding SHALL live in shared package pim_cmp_pkg.
REQ-036 The per-digit borrow/equality logic SHALL be the sub-module cmp_serial_digit, with:
  - parameters DIGIT and IMPL_TYPE;
  - inputs a_d, b_d, bin;
  - outputs bout, deq.
REQ-037 cmp_serial_nbit SHALL instantiate cmp_serial_digit exactly once.
REQ-038 The counter SHALL be $clog2(NDIG)+1 bits wide.
REQ-039 There SHALL be no combinational path from in_valid or out_ready to y.

Verification
REQ-040 Bench SHALL cover, with WIDTH=8 and DIGIT=2: a=0xFF, b=0x01, op=LT. With is_signed=1, y=1 at 4 cycles after accept; with is_signed=0, y=0.
REQ-041 Bench SHALL cover, with WIDTH=8 and DIGIT=2: a=0x80, b=0x7F, is_signed=1, op=LT -> y=1; the same with op=NE -> y=1; with is_signed=0, op=LT -> y=0.
REQ-042 Bench SHALL cover, with WIDTH=8 and DIGIT=2: a=b=0x5A -> EQ y=1, LE y=1, LT y=0, NE y=0.
REQ-043 Bench SHALL cover, with WIDTH=8 and DIGIT=2: out_ready held 0 for 3 cycles in DONE -> out_valid=1, y constant, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-044 Bench SHALL cover, with WIDTH=8 and DIGIT=2: rst_n pulsed low 2 cycles into BUSY -> out_valid=0, y=0, in_ready=1 immediately; no stale result is presented afterwards.
REQ-045 Bench SHALL cover, with WIDTH=8 and DIGIT=8: back-to-back requests -> each result 1 cycle after accept.
REQ-046 Bench SHALL cover a 1000-request random run checked against a reference model.
